// File: rtl/data_sync_pkg.sv
// Shared constants for the multi-channel MCP bus synchronizer.
// Mode encodings and the legal synchronizer depth range live here.
package data_sync_pkg;

  localparam int SYNC_MODE_LEVEL  = 0;
  localparam int SYNC_MODE_TOGGLE = 1;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

endpackage

// File: rtl/data_sync_ch.sv
// One synchronizer channel: control flop chain, edge detect, data capture,
// and valid/overrun bookkeeping for the consumer handshake.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = SYNC_MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 ready_i,
  input  logic                 overrun_clr_i,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic                 pulse_o,
  output logic                 valid_o,
  output logic                 overrun_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  edge_q;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  pulse_q, pulse_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  det;

  always_comb begin
    det = 1'b0;
    if (TOGGLE_MODE == SYNC_MODE_TOGGLE) det = sync_q[NUM_STAGES-1] ^ edge_q;
    else                                 det = sync_q[NUM_STAGES-1] & ~edge_q;
  end

  // A new word always wins: it overwrites, keeps valid high, and flags overrun
  // only when the previous word was neither consumed nor being consumed.
  always_comb begin
    data_d    = data_q;
    pulse_d   = det;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (overrun_clr_i) overrun_d = 1'b0;
    if (det) begin
      data_d  = data_i;
      valid_d = 1'b1;
      if (valid_q && !ready_i) overrun_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      data_q    <= '0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[NUM_STAGES-2:0], enable_i};
      edge_q    <= sync_q[NUM_STAGES-1];
      data_q    <= data_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign pulse_o   = pulse_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel MCP bus synchronizer: NUM_CH independent channels into CLK,
// sharing a single overrun clear.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = SYNC_MODE_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           overrun
);

  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_depth
    $error("data_sync_mc: NUM_STAGES out of legal range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_ch #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_ch (
      .CLK          (CLK),
      .RST          (RST),
      .data_i       (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .enable_i     (bus_enable[c]),
      .ready_i      (sync_ready[c]),
      .overrun_clr_i(overrun_clr),
      .data_o       (sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .pulse_o      (enable_pulse[c]),
      .valid_o      (sync_valid[c]),
      .overrun_o    (overrun[c])
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc: a level-mode (2-stage) and a toggle-mode
// (3-stage) instance driven from one linear stimulus sequence.
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [31:0] lvlBus = '0;
  logic [3:0]  lvlEn = '0, lvlReady = '0;
  logic        lvlClr = 1'b0;
  logic [31:0] lvlSyncBus;
  logic [3:0]  lvlPulse, lvlValid, lvlOverrun;

  logic [31:0] tglBus = '0;
  logic [3:0]  tglEn = '0, tglReady = '0;
  logic        tglClr = 1'b0;
  logic [31:0] tglSyncBus;
  logic [3:0]  tglPulse, tglValid, tglOverrun;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(0)) dutLvl (
    .CLK(CLK), .RST(RST), .unsync_bus(lvlBus), .bus_enable(lvlEn), .sync_ready(lvlReady),
    .overrun_clr(lvlClr), .sync_bus(lvlSyncBus), .enable_pulse(lvlPulse),
    .sync_valid(lvlValid), .overrun(lvlOverrun)
  );

  data_sync_mc #(.NUM_STAGES(3), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(1)) dutTgl (
    .CLK(CLK), .RST(RST), .unsync_bus(tglBus), .bus_enable(tglEn), .sync_ready(tglReady),
    .overrun_clr(tglClr), .sync_bus(tglSyncBus), .enable_pulse(tglPulse),
    .sync_valid(tglValid), .overrun(tglOverrun)
  );

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int cnt;
    int pos;
    int bad;
    logic [7:0] data;
    logic [7:0] prevData;

    applyStimulus(2);
    RST = 1'b0;
    #1;
    checkOutput("reset_bus", lvlSyncBus, 32'h0);
    checkOutput("reset_pulse", {28'h0, lvlPulse}, 32'h0);
    checkOutput("reset_valid", {28'h0, lvlValid}, 32'h0);
    checkOutput("reset_overrun", {28'h0, lvlOverrun}, 32'h0);
    applyStimulus(2);
    RST = 1'b1;
    applyStimulus(3);

    $display("[TB] level mode single event on ch0");
    lvlBus[7:0] = 8'hA5;
    lvlEn[0] = 1'b1;
    applyStimulus(2);
    checkOutput("lvl_pulse_early", {28'h0, lvlPulse}, 32'h0);
    applyStimulus(1);
    checkOutput("lvl_pulse", {28'h0, lvlPulse}, 32'h1);
    checkOutput("lvl_data", {24'h0, lvlSyncBus[7:0]}, 32'hA5);
    checkOutput("lvl_valid", {28'h0, lvlValid}, 32'h1);
    applyStimulus(1);
    checkOutput("lvl_pulse_one_cycle", {28'h0, lvlPulse}, 32'h0);
    checkOutput("lvl_valid_held", {28'h0, lvlValid}, 32'h1);
    lvlReady[0] = 1'b1;
    applyStimulus(1);
    lvlReady[0] = 1'b0;
    checkOutput("lvl_valid_consumed", {28'h0, lvlValid}, 32'h0);
    lvlEn[0] = 1'b0;
    applyStimulus(4);
    checkOutput("lvl_fall_no_pulse", {28'h0, lvlPulse}, 32'h0);

    $display("[TB] overrun on ch2");
    lvlBus[23:16] = 8'h11;
    lvlEn[2] = 1'b1;
    applyStimulus(3);
    checkOutput("ovr_first_valid", {28'h0, lvlValid}, 32'h4);
    lvlEn[2] = 1'b0;
    applyStimulus(3);
    lvlBus[23:16] = 8'h22;
    lvlEn[2] = 1'b1;
    applyStimulus(3);
    checkOutput("ovr_pulse", {28'h0, lvlPulse}, 32'h4);
    checkOutput("ovr_flag", {28'h0, lvlOverrun}, 32'h4);
    checkOutput("ovr_data", {24'h0, lvlSyncBus[23:16]}, 32'h22);
    checkOutput("ovr_valid", {28'h0, lvlValid}, 32'h4);
    lvlClr = 1'b1;
    applyStimulus(1);
    lvlClr = 1'b0;
    checkOutput("ovr_cleared", {28'h0, lvlOverrun}, 32'h0);
    lvlEn[2] = 1'b0;
    applyStimulus(3);
    lvlBus[23:16] = 8'h33;
    lvlEn[2] = 1'b1;
    applyStimulus(2);
    lvlClr = 1'b1;
    applyStimulus(1);
    lvlClr = 1'b0;
    checkOutput("ovr_set_beats_clr", {28'h0, lvlOverrun}, 32'h4);
    checkOutput("ovr_data2", {24'h0, lvlSyncBus[23:16]}, 32'h33);
    lvlClr = 1'b1;
    applyStimulus(1);
    lvlClr = 1'b0;
    checkOutput("ovr_cleared2", {28'h0, lvlOverrun}, 32'h0);
    lvlReady[2] = 1'b1;
    applyStimulus(1);
    lvlReady[2] = 1'b0;
    checkOutput("ovr_consumed", {28'h0, lvlValid}, 32'h0);
    lvlEn[2] = 1'b0;
    applyStimulus(3);

    $display("[TB] simultaneous events on all channels");
    lvlBus = 32'h08040201;
    lvlEn = 4'hF;
    applyStimulus(3);
    checkOutput("sim_pulse", {28'h0, lvlPulse}, 32'hF);
    checkOutput("sim_data", lvlSyncBus, 32'h08040201);
    checkOutput("sim_valid", {28'h0, lvlValid}, 32'hF);
    applyStimulus(1);
    checkOutput("sim_pulse_off", {28'h0, lvlPulse}, 32'h0);
    lvlEn[3] = 1'b0;
    applyStimulus(3);
    lvlBus[31:24] = 8'h77;
    lvlEn[3] = 1'b1;
    applyStimulus(2);
    lvlReady[3] = 1'b1;
    applyStimulus(1);
    lvlReady[3] = 1'b0;
    checkOutput("hs_det_pulse", {28'h0, lvlPulse}, 32'h8);
    checkOutput("hs_det_valid", {31'h0, lvlValid[3]}, 32'h1);
    checkOutput("hs_det_no_overrun", {28'h0, lvlOverrun}, 32'h0);
    checkOutput("hs_det_data", {24'h0, lvlSyncBus[31:24]}, 32'h77);
    lvlEn = 4'h0;
    lvlReady = 4'hF;
    applyStimulus(3);
    lvlReady = 4'h0;
    checkOutput("all_consumed", {28'h0, lvlValid}, 32'h0);

    $display("[TB] reset mid-operation and reset release");
    lvlBus[7:0] = 8'h5A;
    lvlEn[0] = 1'b1;
    applyStimulus(2);
    RST = 1'b0;
    #1;
    checkOutput("mid_rst_bus", lvlSyncBus, 32'h0);
    checkOutput("mid_rst_pulse", {28'h0, lvlPulse}, 32'h0);
    lvlEn[0] = 1'b0;
    applyStimulus(1);
    RST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      if (lvlPulse[0]) cnt++;
    end
    checkOutput("mid_rst_dropped", cnt, 0);
    RST = 1'b0;
    #1;
    lvlEn[0] = 1'b1;
    applyStimulus(1);
    RST = 1'b1;
    cnt = 0;
    pos = 0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1);
      if (lvlPulse[0]) begin
        cnt++;
        pos = i;
      end
    end
    checkOutput("rel_pulse_count", cnt, 1);
    checkOutput("rel_pulse_pos", pos, 3);
    lvlEn[0] = 1'b0;
    lvlReady = 4'hF;
    applyStimulus(4);
    lvlReady = 4'h0;

    $display("[TB] toggle mode on ch1");
    tglBus[15:8] = 8'h3C;
    tglEn[1] = 1'b1;
    applyStimulus(3);
    checkOutput("tgl_rise_early", {28'h0, tglPulse}, 32'h0);
    applyStimulus(1);
    checkOutput("tgl_rise_pulse", {28'h0, tglPulse}, 32'h2);
    checkOutput("tgl_rise_data", {24'h0, tglSyncBus[15:8]}, 32'h3C);
    applyStimulus(1);
    checkOutput("tgl_rise_off", {28'h0, tglPulse}, 32'h0);
    applyStimulus(5);
    tglBus[15:8] = 8'hC3;
    tglEn[1] = 1'b0;
    applyStimulus(3);
    checkOutput("tgl_fall_early", {28'h0, tglPulse}, 32'h0);
    applyStimulus(1);
    checkOutput("tgl_fall_pulse", {28'h0, tglPulse}, 32'h2);
    checkOutput("tgl_fall_data", {24'h0, tglSyncBus[15:8]}, 32'hC3);
    checkOutput("tgl_fall_overrun", {28'h0, tglOverrun}, 32'h2);

    $display("[TB] asynchronous skew on ch1");
    lvlReady[1] = 1'b1;
    prevData = lvlSyncBus[15:8];
    for (int k = 0; k < 10; k++) begin
      data = 8'($urandom_range(0, 255));
      #($urandom_range(1, 9));
      lvlBus[15:8] = data;
      #($urandom_range(1, 9));
      lvlEn[1] = 1'b1;
      cnt = 0;
      bad = 0;
      pos = 0;
      repeat (7) begin
        @(negedge CLK);
        if (lvlSyncBus[15:8] !== prevData && lvlSyncBus[15:8] !== data) bad++;
        if (lvlPulse[1]) begin
          cnt++;
          pos = {24'h0, lvlSyncBus[15:8]};
        end
      end
      checkOutput("skew_pulse_count", cnt, 1);
      checkOutput("skew_data", pos, {24'h0, data});
      checkOutput("skew_no_glitch", bad, 0);
      lvlEn[1] = 1'b0;
      repeat (4) @(negedge CLK);
      prevData = data;
    end
    checkOutput("skew_no_overrun", {31'h0, lvlOverrun[1]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
